dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port 256x64 data memory. Port 0 is the CPU load/store stage and port 1 is the DMA/debug loader. The block accepts one request at a time, registers it, and drives the memory's adr/datain/w/r for exactly one cycle. It captures the memory's combinational read data and returns a one-cycle completion pulse to the winning requester.

Parameters:
ADDR_W, 8, requester address width; zero-extended to the 64-bit memory address (legal 1..64)
DATA_W, 64, data width; must match the memory word

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held with fields stable until p0_gnt seen
p0_we  in  1  port 0 op: 1 = write, 0 = read
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 request accepted (1-cycle pulse)
p0_done  out  1  port 0 op complete (1-cycle pulse); rdata valid if read
p0_rdata  out  DATA_W  port 0 read data, held until next port 0 read completes
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1
mem_adr  out  64  to memory adr
mem_datain  out  DATA_W  to memory datain
mem_w  out  1  to memory w
mem_r  out  1  to memory r
mem_dataout  in  DATA_W  from memory dataout (combinational; high-Z when r = 0)
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all gnt/done/mem_w/mem_r/busy = 0; mem_adr, mem_datain, p0_rdata, p1_rdata = 0; latched request registers cleared; round-robin pointer = port 1.
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, arbitrate, latch winner's id/we/addr/wdata, then go to ACCESS. Otherwise stay.
- ACCESS (exactly 1 cycle):
  - winner's gnt = 1.
  - mem_adr = {zeros, addr}; mem_datain = wdata.
  - Write: mem_w = 1, mem_r = 0; memory commits at the closing edge.
  - Read: mem_r = 1, mem_w = 0; mem_dataout is sampled at the closing edge into the winner's rdata register.
  - Always go to RESP.
- RESP (1 cycle): winner's done = 1. Arbitrate again exactly as in IDLE. A pending request goes directly to ACCESS; otherwise go to IDLE.
- Outside ACCESS: mem_w = mem_r = 0, mem_adr = 0, mem_datain = 0. The memory is never read or written outside ACCESS.
- Requesters drop or change req only after the edge at which gnt was seen high. req is not sampled in ACCESS.
- Latency: req rises in IDLE → gnt next cycle → done the cycle after. Back-to-back throughput: one op per 2 cycles.
- The loser's req stays pending and is served in the next arbitration with no loss.
- A read never disturbs the non-winning port's rdata.
- Reset asserted during ACCESS: mem_w drops immediately, so no write occurs at the following edge. No done pulse is issued; the requester reissues.
- Fixed priority (default build): port 0 wins whenever both req are high.

Optional Feature:
MEMARB_RR_EN:
- Defined: round-robin arbitration. On a tie, the port not granted last wins. The pointer updates at each ACCESS entry. After reset the pointer is port 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties, and no pointer register exists.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then idle, no req → all outputs 0, busy = 0, mem_w = mem_r = 0 for 10 cycles.
- p0 write addr 0x05, data 0xDEADBEEF_00000001 → p0_gnt at cycle 1 with mem_w = 1, mem_adr = 0x5. p0_done at cycle 2. A following p0 read of 0x05 returns p0_rdata = 0xDEADBEEF_00000001 with p0_done.
- p0 and p1 req same cycle, reads of 0x10 and 0x20 preloaded 0xA and 0xB:
  - Default build: p0 is served first; p1_gnt arrives in the cycle after p0_done (RESP → ACCESS); p0_rdata = 0xA, p1_rdata = 0xB.
- Same stimulus with MEMARB_RR_EN, repeated 4 times with both reqs held → grants alternate 0,1,0,1. Default build → p0 is granted every time p0 re-requests, and p1 only when p0_req is low.
- p1 read of 0x30 while p0_rdata holds 0x77 → p0_rdata stays 0x77; p1_rdata updates.
- rst_n pulled low during ACCESS of a p1 write to 0x40 (old 0x1) → mem_w falls asynchronously, 0x40 reads back 0x1 after reset, and no p1_done pulse.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port arbiter/sequencer for the single-port 256x64 data memory.
//            Define MEMARB_RR_EN for round-robin ties (default: port 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [63:0]       mem_adr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_w,
    output logic              mem_r,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;
    logic                w_any;
    logic                w_arb;
    logic                w_win;

    assign w_any = p0_req | p1_req;
    assign w_arb = ((r_state == S_IDLE) || (r_state == S_RESP)) && w_any;

`ifdef MEMARB_RR_EN
    // r_last holds the most recently granted port; ties go to the other one.
    logic r_last;

    assign w_win = (p0_req && p1_req) ? ~r_last : ~p0_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_arb) begin
            r_last <= w_win;
        end
    end
`else
    assign w_win = ~p0_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = w_any ? S_ACCESS : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_arb) begin
            r_id    <= w_win;
            r_we    <= w_win ? p1_we    : p0_we;
            r_addr  <= w_win ? p1_addr  : p0_addr;
            r_wdata <= w_win ? p1_wdata : p0_wdata;
        end
    end

    // Read data lands only in the winner's register; the other port keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else if ((r_state == S_ACCESS) && !r_we) begin
            if (r_id) begin
                r_p1_rdata <= mem_dataout;
            end else begin
                r_p0_rdata <= mem_dataout;
            end
        end
    end

    // Memory strobes decode straight from state so an async reset kills them at once.
    always_comb begin
        p0_gnt     = 1'b0;
        p1_gnt     = 1'b0;
        p0_done    = 1'b0;
        p1_done    = 1'b0;
        mem_adr    = '0;
        mem_datain = '0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        busy       = (r_state != S_IDLE);
        if (r_state == S_ACCESS) begin
            p0_gnt                = ~r_id;
            p1_gnt                = r_id;
            mem_adr[ADDR_W-1:0]   = r_addr;
            mem_datain            = r_wdata;
            mem_w                 = r_we;
            mem_r                 = ~r_we;
        end
        if (r_state == S_RESP) begin
            p0_done = ~r_id;
            p1_done = r_id;
        end
    end

    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a 256x64 memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [7:0]  p0_addr = '0;
    logic [63:0] p0_wdata = '0;
    logic        p0_gnt, p0_done;
    logic [63:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [7:0]  p1_addr = '0;
    logic [63:0] p1_wdata = '0;
    logic        p1_gnt, p1_done;
    logic [63:0] p1_rdata;
    logic [63:0] mem_adr, mem_datain, mem_dataout;
    logic        mem_w, mem_r, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_adr = '0;
    logic [63:0] pl_dat = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w) mem[mem_adr[7:0]] <= mem_datain;
        else if (pl_en) mem[pl_adr] <= pl_dat;
    end
    assign mem_dataout = mem_r ? mem[mem_adr[7:0]] : 64'bz;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_adr(mem_adr), .mem_datain(mem_datain), .mem_w(mem_w), .mem_r(mem_r),
        .mem_dataout(mem_dataout), .busy(busy)
    );

    // Observations of one batch, indexed by port.
    int          og[2];
    int          od[2];
    logic [63:0] ord[2];
    logic        ow[2];
    logic        orr[2];
    logic [63:0] oadr[2];
    logic [63:0] odin[2];
    int          ordq[$];

    task automatic do_reset();
        rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0; pl_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue up to one request per port from an idle DUT; record what happens.
    task automatic run_batch(input bit e0, input bit w0, input logic [7:0] a0, input logic [63:0] d0,
                             input bit e1, input bit w1, input logic [7:0] a1, input logic [63:0] d1);
        og = '{-1, -1}; od = '{-1, -1};
        ordq.delete();
        p0_req = e0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = e1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        for (int c = 0; c < 20; c++) begin
            bit g0, g1;
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            if (p0_gnt) begin
                og[0] = c; ow[0] = mem_w; orr[0] = mem_r; oadr[0] = mem_adr; odin[0] = mem_datain;
                ordq.push_back(0);
            end
            if (p1_gnt) begin
                og[1] = c; ow[1] = mem_w; orr[1] = mem_r; oadr[1] = mem_adr; odin[1] = mem_datain;
                ordq.push_back(1);
            end
            if (p0_done) begin od[0] = c; ord[0] = p0_rdata; end
            if (p1_done) begin od[1] = c; ord[1] = p1_rdata; end
            @(posedge clk); #1;
            if (g0) p0_req = 1'b0;
            if (g1) p1_req = 1'b0;
            if ((!e0 || od[0] >= 0) && (!e1 || od[1] >= 0)) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({p0_gnt, p0_done, p1_gnt, p1_done, mem_w, mem_r, busy} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_ctrl cyc %0d: got %b expected 0", i,
                         {p0_gnt, p0_done, p1_gnt, p1_done, mem_w, mem_r, busy});
            end
            n_cmp++;
            if ((mem_adr | mem_datain | p0_rdata | p1_rdata) !== 64'h0) begin
                n_err++;
                $display("FAIL reset_data cyc %0d: adr=%h din=%h rd0=%h rd1=%h expected 0",
                         i, mem_adr, mem_datain, p0_rdata, p1_rdata);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        run_batch(1, 1, 8'h05, 64'hDEADBEEF_00000001, 0, 0, 8'h00, 64'h0);
        n_cmp++; if (og[0] !== 1) begin n_err++; $display("FAIL wr_gnt_cycle: got %0d expected 1", og[0]); end
        n_cmp++; if ({ow[0], orr[0]} !== 2'b10) begin n_err++; $display("FAIL wr_strobes: got w/r=%b expected 10", {ow[0], orr[0]}); end
        n_cmp++; if (oadr[0] !== 64'h5) begin n_err++; $display("FAIL wr_adr: got %h expected 5", oadr[0]); end
        n_cmp++; if (odin[0] !== 64'hDEADBEEF_00000001) begin n_err++; $display("FAIL wr_din: got %h expected deadbeef00000001", odin[0]); end
        n_cmp++; if (od[0] !== 2) begin n_err++; $display("FAIL wr_done_cycle: got %0d expected 2", od[0]); end
        run_batch(1, 0, 8'h05, 64'h0, 0, 0, 8'h00, 64'h0);
        n_cmp++; if ({ow[0], orr[0]} !== 2'b01) begin n_err++; $display("FAIL rd_strobes: got w/r=%b expected 01", {ow[0], orr[0]}); end
        n_cmp++; if (od[0] !== 2) begin n_err++; $display("FAIL rd_done_cycle: got %0d expected 2", od[0]); end
        n_cmp++; if (ord[0] !== 64'hDEADBEEF_00000001) begin n_err++; $display("FAIL rd_data: got %h expected deadbeef00000001", ord[0]); end
    endtask

    task automatic test_tie();
        do_reset();
        preload(8'h10, 64'hA);
        preload(8'h20, 64'hB);
        run_batch(1, 0, 8'h10, 64'h0, 1, 0, 8'h20, 64'h0);
        n_cmp++; if (og[0] !== 1 || od[0] !== 2) begin n_err++; $display("FAIL tie_p0_timing: got gnt %0d done %0d expected 1 2", og[0], od[0]); end
        n_cmp++; if (og[1] !== 3 || od[1] !== 4) begin n_err++; $display("FAIL tie_p1_timing: got gnt %0d done %0d expected 3 4", og[1], od[1]); end
        n_cmp++; if (ord[0] !== 64'hA) begin n_err++; $display("FAIL tie_p0_rdata: got %h expected a", ord[0]); end
        n_cmp++; if (ord[1] !== 64'hB) begin n_err++; $display("FAIL tie_p1_rdata: got %h expected b", ord[1]); end
    endtask

    task automatic test_alternation();
        int exp4[4];
        do_reset();
        ordq.delete();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h20;
        for (int c = 0; c < 40 && (p0_req || p1_req); c++) begin
            bit g0, g1;
            @(negedge clk);
            g0 = p0_gnt; g1 = p1_gnt;
            if (p0_gnt) ordq.push_back(0);
            if (p1_gnt) ordq.push_back(1);
            @(posedge clk); #1;
            if (ordq.size() >= 4) begin
                if (g0) p0_req = 1'b0;
                if (g1) p1_req = 1'b0;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        exp4 = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        n_cmp++;
        if (ordq.size() < 5) begin
            n_err++; $display("FAIL alt_count: got %0d grants expected 5", ordq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ordq[i] !== exp4[i]) begin n_err++; $display("FAIL alt_grant%0d: got port %0d expected %0d", i, ordq[i], exp4[i]); end
            end
            n_cmp++;
            if (ordq[4] !== (RR ? 0 : 1)) begin n_err++; $display("FAIL alt_grant4: got port %0d expected %0d", ordq[4], RR ? 0 : 1); end
        end
    endtask

    task automatic test_isolation();
        preload(8'h50, 64'h77);
        preload(8'h30, 64'h1234_5678_9ABC_DEF0);
        run_batch(1, 0, 8'h50, 64'h0, 0, 0, 8'h00, 64'h0);
        n_cmp++; if (ord[0] !== 64'h77) begin n_err++; $display("FAIL iso_p0_rdata: got %h expected 77", ord[0]); end
        run_batch(0, 0, 8'h00, 64'h0, 1, 0, 8'h30, 64'h0);
        n_cmp++; if (ord[1] !== 64'h1234_5678_9ABC_DEF0) begin n_err++; $display("FAIL iso_p1_rdata: got %h expected 123456789abcdef0", ord[1]); end
        n_cmp++; if (p0_rdata !== 64'h77) begin n_err++; $display("FAIL iso_p0_held: got %h expected 77", p0_rdata); end
    endtask

    task automatic test_reset_during_access();
        bit seen_done;
        seen_done = 1'b0;
        preload(8'h40, 64'h1);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h40; p1_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        n_cmp++; if ({p1_gnt, mem_w} !== 2'b11) begin n_err++; $display("FAIL rda_access: got gnt/w=%b expected 11", {p1_gnt, mem_w}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_w, busy} !== 2'b00) begin n_err++; $display("FAIL rda_async_drop: got w/busy=%b expected 00", {mem_w, busy}); end
        p1_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (p1_done) seen_done = 1'b1;
            if (c == 2) rst_n = 1'b1;
        end
        @(posedge clk); #1;
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL rda_no_done: got done seen=%b expected 0", seen_done); end
        n_cmp++; if (mem[8'h40] !== 64'h1) begin n_err++; $display("FAIL rda_mem_kept: got %h expected 1", mem[8'h40]); end
        run_batch(0, 0, 8'h00, 64'h0, 1, 0, 8'h40, 64'h0);
        n_cmp++; if (ord[1] !== 64'h1) begin n_err++; $display("FAIL rda_readback: got %h expected 1", ord[1]); end
    endtask

    task automatic test_random();
        logic [63:0] sh[16];
        logic [63:0] exp_rd[2];
        bit          en[2], we[2];
        logic [7:0]  ad[2];
        logic [63:0] dt[2];
        int          first, model_last, slot, p;
        do_reset();
        model_last = 1;
        exp_rd = '{64'h0, 64'h0};
        for (int i = 0; i < 16; i++) begin
            sh[i] = {$urandom, $urandom};
            preload(8'(i), sh[i]);
        end
        for (int it = 0; it < 30; it++) begin
            for (int q = 0; q < 2; q++) begin
                en[q] = 1'($urandom_range(0, 1));
                we[q] = 1'($urandom_range(0, 1));
                ad[q] = 8'($urandom_range(0, 15));
                dt[q] = {$urandom, $urandom};
            end
            if (!en[0] && !en[1]) en[$urandom_range(0, 1)] = 1'b1;
            if (en[0] && en[1]) first = RR ? (1 - model_last) : 0;
            else                first = en[0] ? 0 : 1;
            run_batch(en[0], we[0], ad[0], dt[0], en[1], we[1], ad[1], dt[1]);
            for (int k = 0; k < 2; k++) begin
                p = (k == 0) ? first : 1 - first;
                if (en[p]) begin
                    slot = k;
                    if (we[p]) sh[ad[p][3:0]] = dt[p];
                    else       exp_rd[p] = sh[ad[p][3:0]];
                    model_last = p;
                    n_cmp++;
                    if (og[p] !== 1 + 2 * slot || od[p] !== 2 + 2 * slot) begin
                        n_err++;
                        $display("FAIL rnd%0d_p%0d_timing: got gnt %0d done %0d expected %0d %0d",
                                 it, p, og[p], od[p], 1 + 2 * slot, 2 + 2 * slot);
                    end
                end
            end
            n_cmp++;
            if (p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin
                n_err++;
                $display("FAIL rnd%0d_rdata: got %h %h expected %h %h", it, p0_rdata, p1_rdata, exp_rd[0], exp_rd[1]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem[i] !== sh[i]) begin n_err++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, mem[i], sh[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_alternation();
        test_isolation();
        test_reset_during_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
